// File: rtl/egg_timer_pkg.sv
// -----------------------------------------------------------------------------
// egg_timer_pkg
// Shared types and constants for the egg timer countdown controller.
//   state_t : controller state encoding (IDLE, RUN, PAUSE, ALARM)
//   SEC_MAX : highest seconds value (seconds roll 59 -> 0 when set)
//   MIN_W   : width of the minutes register
//   SEC_W   : width of the seconds register
// -----------------------------------------------------------------------------
package egg_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam int SEC_MAX = 59;
    localparam int MIN_W   = 7;
    localparam int SEC_W   = 6;

endpackage

// File: rtl/egg_tick_gen.sv
// -----------------------------------------------------------------------------
// egg_tick_gen
// Enable-style 1 Hz prescaler. Counts clk cycles while en is high and raises
// tick for the single cycle in which the count sits at TICKS_PER_SEC-1; the
// count wraps to 0 on that edge. clr forces the count to 0 and masks tick.
// While en is low (and clr low) the count holds, so a paused countdown keeps
// its fractional second.
//
// Parameters:
//   TICKS_PER_SEC : clk cycles per tick (minimum 2)
// Ports:
//   clk   in  system clock
//   reset in  asynchronous, active-high reset
//   en    in  count enable
//   clr   in  synchronous clear (priority over en)
//   tick  out one-cycle strobe, combinational from the count
// -----------------------------------------------------------------------------
module egg_tick_gen #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt;

    // Masked by clr so an abort on the terminal cycle never leaks a tick.
    assign tick = en && !clr && (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/egg_timer_ctrl.sv
// -----------------------------------------------------------------------------
// egg_timer_ctrl
// Countdown controller for the egg timer: owns the MM:SS registers, the
// set/start/pause/clear sequencing and the alarm timing. The 1 Hz timebase is
// an enable strobe from egg_tick_gen, so everything runs on clk.
//
// Build option:
//   EGG_TIMER_ALARM_BLINK_EN : when defined, alarm toggles on every tick while
//   in ALARM (1 s on / 1 s off, starting on); otherwise alarm is steady high.
//
// Parameters:
//   TICKS_PER_SEC : clk cycles per second (minimum 2)
//   MAX_MIN       : highest settable minutes value (wraps to 0 when set)
//   ALARM_SECS    : seconds the alarm sounds before returning to IDLE
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous, active-high reset
//   start_stop in  pulse: start / pause / resume / silence
//   clear      in  pulse: abort to IDLE with time 0:00
//   inc_min    in  pulse: minutes +1 (IDLE only)
//   inc_sec    in  pulse: seconds +1 (IDLE only)
//   minutes    out current minutes, 0..MAX_MIN
//   seconds    out current seconds, 0..59
//   running    out high in RUN (registered)
//   alarm      out buzzer drive (registered)
//   tick       out registered copy of the 1 Hz strobe, aligned with the
//                  updated time value
// -----------------------------------------------------------------------------
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int MAX_MIN       = 99,
    parameter int ALARM_SECS    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             inc_min,
    input  logic             inc_sec,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             running,
    output logic             alarm,
    output logic             tick
);

    localparam int ACNT_W = $clog2(ALARM_SECS + 1);
    localparam logic [ACNT_W-1:0] ALARM_LAST = ACNT_W'(ALARM_SECS - 1);
    localparam logic [MIN_W-1:0]  MIN_LAST   = MIN_W'(MAX_MIN);
    localparam logic [SEC_W-1:0]  SEC_LAST   = SEC_W'(SEC_MAX);

    state_t            state;
    logic [ACNT_W-1:0] alarm_cnt;
    logic              tick_en;
    logic              tick_clr;
    logic              tick_int;
    logic              time_zero;
    logic              last_sec;

    assign tick_en   = (state == RUN) || (state == ALARM);
    assign tick_clr  = (state == IDLE) || clear;
    assign time_zero = (minutes == '0) && (seconds == '0);
    // The next decrement lands on 0:00.
    assign last_sec  = (minutes == '0) && (seconds == SEC_W'(1));

    egg_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick_int)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            minutes   <= '0;
            seconds   <= '0;
            running   <= 1'b0;
            alarm     <= 1'b0;
            tick      <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            tick <= tick_int;
            if (clear) begin
                state     <= IDLE;
                minutes   <= '0;
                seconds   <= '0;
                running   <= 1'b0;
                alarm     <= 1'b0;
                alarm_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_stop) begin
                            if (!time_zero) begin
                                state   <= RUN;
                                running <= 1'b1;
                            end
                        end else begin
                            if (inc_min) begin
                                minutes <= (minutes == MIN_LAST) ? '0 : minutes + MIN_W'(1);
                            end
                            if (inc_sec) begin
                                seconds <= (seconds == SEC_LAST) ? '0 : seconds + SEC_W'(1);
                            end
                        end
                    end

                    RUN: begin
                        // A tick coinciding with start_stop still counts, and
                        // reaching 0:00 wins over pausing.
                        if (tick_int) begin
                            if (seconds != '0) begin
                                seconds <= seconds - SEC_W'(1);
                            end else begin
                                minutes <= minutes - MIN_W'(1);
                                seconds <= SEC_LAST;
                            end
                        end
                        if (tick_int && last_sec) begin
                            state     <= ALARM;
                            running   <= 1'b0;
                            alarm     <= 1'b1;
                            alarm_cnt <= '0;
                        end else if (start_stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end

                    PAUSE: begin
                        if (start_stop) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end

                    ALARM: begin
                        if (start_stop) begin
                            state <= IDLE;
                            alarm <= 1'b0;
                        end else if (tick_int) begin
                            if (alarm_cnt == ALARM_LAST) begin
                                state     <= IDLE;
                                alarm     <= 1'b0;
                                alarm_cnt <= '0;
                            end else begin
                                alarm_cnt <= alarm_cnt + ACNT_W'(1);
`ifdef EGG_TIMER_ALARM_BLINK_EN
                                alarm     <= ~alarm;
`else
                                alarm     <= 1'b1;
`endif
                            end
                        end
                    end

                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                        alarm   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_egg_timer_ctrl
// Scoreboard bench for egg_timer_ctrl (TICKS_PER_SEC=4, ALARM_SECS=3,
// MAX_MIN=99). Stimulus pushes the expected output snapshot for every visible
// output event; the monitor pops and compares whenever tick is high or any of
// running/alarm/minutes/seconds changes. Timing is checked directly by the
// stimulus process (cycles between ticks).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_egg_timer_ctrl;

    localparam int TPS = 4;
    localparam int AS  = 3;
    localparam int MM  = 99;

`ifdef EGG_TIMER_ALARM_BLINK_EN
    localparam logic ALM_T1 = 1'b0;
    localparam logic ALM_T2 = 1'b1;
`else
    localparam logic ALM_T1 = 1'b1;
    localparam logic ALM_T2 = 1'b1;
`endif

    typedef struct packed {
        logic       tick;
        logic       running;
        logic       alarm;
        logic [6:0] minutes;
        logic [5:0] seconds;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic       inc_min;
    logic       inc_sec;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       alarm;
    logic       tick;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    m_min    = 0;
    int    m_sec    = 0;

    egg_timer_ctrl #(
        .TICKS_PER_SEC(TPS),
        .MAX_MIN      (MM),
        .ALARM_SECS   (AS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_stop(start_stop),
        .clear     (clear),
        .inc_min   (inc_min),
        .inc_sec   (inc_sec),
        .minutes   (minutes),
        .seconds   (seconds),
        .running   (running),
        .alarm     (alarm),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic t, input logic r, input logic a,
                                input int m, input int s);
        return {t, r, a, 7'(m), 6'(s)};
    endfunction

    function automatic obs_t snap();
        return {tick, running, alarm, minutes, seconds};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
        end
    endtask

    task automatic check_obs(input string name, input obs_t act, input obs_t exp_v);
        check(name, 32'(act), 32'(exp_v));
    endtask

    task automatic push_exp(input string tag, input obs_t o);
        exp_q.push_back(o);
        tag_q.push_back(tag);
    endtask

    // One-cycle pulse: driven after a falling edge, sampled on the next rise.
    task automatic pulse(input bit ss, input bit cl, input bit im, input bit is);
        @(negedge clk);
        start_stop = ss;
        clear      = cl;
        inc_min    = im;
        inc_sec    = is;
        @(negedge clk);
        start_stop = 1'b0;
        clear      = 1'b0;
        inc_min    = 1'b0;
        inc_sec    = 1'b0;
    endtask

    task automatic set_sec();
        m_sec = (m_sec == 59) ? 0 : m_sec + 1;
        push_exp("set_sec", mk(1'b0, 1'b0, 1'b0, m_min, m_sec));
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic set_min();
        m_min = (m_min == MM) ? 0 : m_min + 1;
        push_exp("set_min", mk(1'b0, 1'b0, 1'b0, m_min, m_sec));
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic start_run();
        push_exp("start", mk(1'b0, 1'b1, 1'b0, m_min, m_sec));
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected snapshot for the next countdown tick.
    task automatic push_run_tick();
        if (m_sec > 0) begin
            m_sec = m_sec - 1;
        end else begin
            m_min = m_min - 1;
            m_sec = 59;
        end
        if (m_min == 0 && m_sec == 0)
            push_exp("run_to_alarm", mk(1'b1, 1'b0, 1'b1, 0, 0));
        else
            push_exp("run_tick", mk(1'b1, 1'b1, 1'b0, m_min, m_sec));
    endtask

    // Counts falling edges until tick is seen; bounded so a missing tick fails.
    task automatic wait_tick(input string name, input int exp_n);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < exp_n + 8);
        check(name, 32'(n), 32'(exp_n));
    endtask

    task automatic count_ticks(input string name, input int cycles);
        int n_t;
        n_t = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (tick) n_t++;
        end
        check(name, 32'(n_t), 32'd0);
    endtask

    // Monitor: compares every visible output event against the scoreboard.
    initial begin
        obs_t  cur;
        obs_t  prev;
        obs_t  e;
        string t;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = snap();
            if (cur.tick || cur[14:0] != prev[14:0]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0h required=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    check_obs({"sb_", t}, cur, e);
                end
            end
            prev = cur;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        inc_min    = 1'b0;
        inc_sec    = 1'b0;
        repeat (3) @(negedge clk);
        check_obs("reset_state", snap(), '0);
        reset = 1'b0;

        // Set wrap: seconds 59 -> 0, minutes 99 -> 0, then both together.
        for (int i = 1; i <= 60; i++) begin
            set_sec();
            if (i == 59) check("sec_reach_59", 32'(seconds), 32'd59);
        end
        check("sec_wrap_0", 32'(seconds), 32'd0);
        for (int i = 1; i <= 100; i++) begin
            set_min();
            if (i == 99) check("min_reach_99", 32'(minutes), 32'd99);
        end
        check("min_wrap_0", 32'(minutes), 32'd0);
        m_min = 1;
        m_sec = 1;
        push_exp("both_inc", mk(1'b0, 1'b0, 1'b0, 1, 1));
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        check_obs("both_inc", snap(), mk(1'b0, 1'b0, 1'b0, 1, 1));

        // Countdown 1:01 -> 0:00 with borrow, then alarm expiry.
        start_run();
        for (int k = 1; k <= 61; k++) push_run_tick();
        wait_tick("first_tick_latency", 4);
        for (int k = 2; k <= 61; k++) wait_tick("countdown_tick_period", 4);
        check_obs("alarm_entry", snap(), mk(1'b1, 1'b0, 1'b1, 0, 0));
        push_exp("alarm_t1", mk(1'b1, 1'b0, ALM_T1, 0, 0));
        push_exp("alarm_t2", mk(1'b1, 1'b0, ALM_T2, 0, 0));
        push_exp("alarm_expire", mk(1'b1, 1'b0, 1'b0, 0, 0));
        wait_tick("alarm_tick1", 4);
        wait_tick("alarm_tick2", 4);
        check("alarm_before_expiry", 32'(alarm), 32'(ALM_T2));
        wait_tick("alarm_expiry", 4);
        check_obs("alarm_off_idle", snap(), mk(1'b1, 1'b0, 1'b0, 0, 0));

        // Pause/resume keeps the fractional second.
        repeat (3) set_sec();
        start_run();
        push_run_tick();
        wait_tick("pause_first_tick", 4);
        push_exp("pause", mk(1'b0, 1'b0, 1'b0, 0, 2));
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        count_ticks("pause_no_tick", 20);
        check_obs("pause_frozen", snap(), mk(1'b0, 1'b0, 1'b0, 0, 2));
        push_exp("resume", mk(1'b0, 1'b1, 1'b0, 0, 2));
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        push_run_tick();
        wait_tick("resume_tick_latency", 2);
        check_obs("resume_time", snap(), mk(1'b1, 1'b1, 1'b0, 0, 1));
        push_run_tick();
        wait_tick("pause_run_to_alarm", 4);

        // Silence on cycle 5 of ALARM.
        push_exp("alarm_t1b", mk(1'b1, 1'b0, ALM_T1, 0, 0));
        wait_tick("alarm_tick1b", 4);
        if (ALM_T1) push_exp("silence", mk(1'b0, 1'b0, 1'b0, 0, 0));
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("silence_alarm_off", 32'(alarm), 32'd0);
        count_ticks("silenced_no_ticks", 12);

        // start_stop at 0:00 is ignored.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("start_at_zero_ignored", 32'(running), 32'd0);
        count_ticks("zero_start_no_ticks", 8);

        // inc_sec ignored in RUN, then async reset mid-count at 0:05.
        repeat (5) set_sec();
        start_run();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check_obs("inc_ignored_in_run", snap(), mk(1'b0, 1'b1, 1'b0, 0, 5));
        push_exp("reset_async", mk(1'b0, 1'b0, 1'b0, 0, 0));
        #2 reset = 1'b1;
        #1 check_obs("reset_async", snap(), '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_min = 0;
        m_sec = 0;

        // Prescaler restarts from 0 after reset; clear beats start_stop.
        repeat (2) set_sec();
        start_run();
        push_run_tick();
        wait_tick("post_reset_tick_latency", 4);
        push_exp("clear_prio", mk(1'b0, 1'b0, 1'b0, 0, 0));
        m_sec = 0;
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check_obs("clear_over_start", snap(), mk(1'b0, 1'b0, 1'b0, 0, 0));
        count_ticks("cleared_no_ticks", 8);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
